// File: rtl/bias_add_pkg.sv
// rtl/bias_add_pkg.sv - shared defaults and helpers for the bias-add pipeline
package bias_add_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  // Low bit index of lane k in a packed lane vector.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Largest signed value representable in width bits.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest signed value representable in width bits.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/lane_sat_add.sv
// rtl/lane_sat_add.sv - combinational signed saturating add for one lane
module lane_sat_add
  import bias_add_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam logic signed [DATA_W:0] MAXV = (DATA_W + 1)'(sat_max(DATA_W));
  localparam logic signed [DATA_W:0] MINV = (DATA_W + 1)'(sat_min(DATA_W));

  logic signed [DATA_W:0] sum;

  // Widen by one bit so the sum never overflows, then clamp back to DATA_W.
  always_comb begin
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    y   = sum[DATA_W-1:0];
    sat = 1'b0;
    if (sum > MAXV) begin
      y   = MAXV[DATA_W-1:0];
      sat = 1'b1;
    end else if (sum < MINV) begin
      y   = MINV[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/bias_add_pipe.sv
// rtl/bias_add_pipe.sv - two-stage per-lane bias add with saturation; optional ReLU via BIAS_ADD_RELU_EN
module bias_add_pipe
  import bias_add_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_load,
  input  logic [LANES*DATA_W-1:0]   bias_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_sat,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          sat_count
);

  localparam int W = LANES * DATA_W;

  logic [W-1:0]       bias_q;
  logic               s1_valid;
  logic [W-1:0]       s1_data;
  logic [W-1:0]       s1_bias;
  logic               s2_valid;
  logic [W-1:0]       s2_data;
  logic [LANES-1:0]   s2_sat;
  logic [W-1:0]       sum_data;
  logic [LANES-1:0]   sum_sat;
  logic [W-1:0]       s2_next_data;
  logic               s2_load;
  logic               s1_load;
  logic               sat_fire;

  // A stage may load when it is empty or its beat leaves on this edge.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;

  assign in_ready  = s1_load && !rst;
  assign out_valid = s2_valid && !rst;
  assign out_data  = s2_data;
  assign out_sat   = s2_sat;
  assign sat_fire  = out_valid && out_ready && (|s2_sat);

  // Bias register; beats captured on the same edge still see the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
    end else if (bias_load) begin
      bias_q <= bias_in;
    end
  end

  // Stage 1: operand plus a private snapshot of the bias in force at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_bias  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_bias  <= bias_q;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_sat_add #(
      .DATA_W (DATA_W)
    ) u_lane (
      .a   (s1_data[lane_lo(k, DATA_W) +: DATA_W]),
      .b   (s1_bias[lane_lo(k, DATA_W) +: DATA_W]),
      .y   (sum_data[lane_lo(k, DATA_W) +: DATA_W]),
      .sat (sum_sat[k])
    );
  end

`ifdef BIAS_ADD_RELU_EN
  // Zero any lane whose saturated result is negative; the clamp flag is left as is.
  always_comb begin
    s2_next_data = sum_data;
    for (int k = 0; k < LANES; k++) begin
      if (sum_data[lane_lo(k, DATA_W) + DATA_W - 1]) begin
        s2_next_data[lane_lo(k, DATA_W) +: DATA_W] = '0;
      end
    end
  end
`else
  assign s2_next_data = sum_data;
`endif

  // Stage 2: registered result; held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_data  <= s2_next_data;
      s2_sat   <= sum_sat;
    end
  end

  // Count delivered beats carrying any clamp; sticks at all-ones, clear wins over old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (stat_clr) begin
      sat_count <= sat_fire ? CNT_W'(1) : '0;
    end else if (sat_fire && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bias_add_pipe.sv
// tb/tb_bias_add_pipe.sv - self-checking bench for bias_add_pipe against a queue reference model
module tb_bias_add_pipe;

  localparam int LANES  = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int W      = LANES * DATA_W;

  typedef struct packed {
    logic [LANES-1:0] s;
    logic [W-1:0]     d;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             bias_load;
  logic [W-1:0]     bias_in;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] out_sat;
  logic             stat_clr;
  logic [CNT_W-1:0] sat_count;

  int               vectors = 0;
  int               errors  = 0;

  beat_t            q[$];
  logic [W-1:0]     m_bias;
  logic [CNT_W-1:0] m_cnt;

  bias_add_pipe #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bias_load (bias_load),
    .bias_in   (bias_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .stat_clr  (stat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  // Reference: plain integer add per lane, clamp to the signed range, optional ReLU.
  function automatic beat_t ref_beat(input logic [W-1:0] d, input logic [W-1:0] b);
    beat_t r;
    int    x;
    int    y;
    int    hi;
    int    lo;
    hi = (1 << (DATA_W - 1)) - 1;
    lo = -(1 << (DATA_W - 1));
    for (int k = 0; k < LANES; k++) begin
      x = $signed(d[k*DATA_W +: DATA_W]);
      y = $signed(b[k*DATA_W +: DATA_W]);
      x = x + y;
      r.s[k] = 1'b0;
      if (x > hi) begin
        x = hi;
        r.s[k] = 1'b1;
      end else if (x < lo) begin
        x = lo;
        r.s[k] = 1'b1;
      end
`ifdef BIAS_ADD_RELU_EN
      if (x < 0) x = 0;
`endif
      r.d[k*DATA_W +: DATA_W] = x[DATA_W-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model on the edge.
  task automatic step();
    logic  in_fire;
    logic  out_fire;
    logic  any_sat;
    logic  exp_ready;
    #1;
    exp_ready = !rst && (out_ready || q.size() < 2);
    chk("in_ready", in_ready, exp_ready);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_sat", out_sat, q[0].s);
      end
    end
    in_fire  = in_valid && exp_ready;
    out_fire = (out_valid === 1'b1) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_bias = '0;
      m_cnt  = '0;
    end else begin
      any_sat = out_fire && (q.size() > 0) && (|q[0].s);
      if (out_fire && q.size() > 0) void'(q.pop_front());
      if (in_fire) q.push_back(ref_beat(in_data, m_bias));
      if (bias_load) m_bias = bias_in;
      if (stat_clr) m_cnt = any_sat ? CNT_W'(1) : '0;
      else if (any_sat && m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
    end
    #1;
    chk("sat_count", sat_count, m_cnt);
  endtask

  initial begin
    int sent;
    int delivered;
    logic [W-1:0] exp_v;

    rst = 1'b1; bias_load = 1'b0; bias_in = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; stat_clr = 1'b0;
    m_bias = '0; m_cnt = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sat", out_sat, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // Bias 0x01 everywhere, lanes 0x10..0x17
    bias_in = {LANES{8'h01}}; bias_load = 1'b1;
    step();
    bias_load = 1'b0;
    for (int k = 0; k < LANES; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'(16 + k);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 1'b0);
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("inc_data", out_data, 64'h1817161514131211);
    chk("inc_sat", out_sat, '0);
    step();

    // Positive and negative clamp, counter from zero
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    bias_in = 64'h0000_0000_0000_FF01; bias_load = 1'b1;
    step();
    bias_load = 1'b0;
    in_data = 64'h0000_0000_0000_807F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
`ifdef BIAS_ADD_RELU_EN
    chk("clamp_data", out_data[15:0], 16'h007F);
`else
    chk("clamp_data", out_data[15:0], 16'h807F);
`endif
    chk("clamp_sat", out_sat[1:0], 2'b11);
    step();
    chk("clamp_count", sat_count, 16'd1);

    // Bias update on the same edge as beat A
    bias_in = '0; bias_load = 1'b1;
    step();
    bias_in = {LANES{8'h05}}; in_data = {LANES{8'h20}}; in_valid = 1'b1;
    step();
    bias_load = 1'b0; in_data = {LANES{8'h30}};
    step();
    in_valid = 1'b0;
    chk("bias_old_A", out_data, {LANES{8'h20}});
    step();
    chk("bias_new_B", out_data, {LANES{8'h35}});
    step();

    // Six-beat stream with a three-cycle downstream stall
    sent = 0; delivered = 0;
    in_data = {$urandom, $urandom};
    for (int cyc = 0; cyc < 30 && (sent < 6 || q.size() > 0); cyc++) begin
      in_valid  = (sent < 6);
      out_ready = !(cyc >= 2 && cyc < 5);
      if (cyc == 3) begin
        #1;
        chk("stall_in_ready_low", in_ready, 1'b0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) delivered++;
      step();
      if (in_valid && in_ready === 1'b0) begin
      end else begin
        in_data = {$urandom, $urandom};
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_delivered", delivered, 6);

    // Random traffic, bias loads and counter clears
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      bias_in   = {$urandom, $urandom};
      bias_load = ($urandom % 8) == 0;
      stat_clr  = ($urandom % 16) == 0;
      step();
    end
    in_valid = 1'b0; bias_load = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    step();
    in_data = {$urandom, $urandom};
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_count", sat_count, '0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_stale", out_valid, 1'b0);
    end

    // Negative non-clamped lane: ReLU zeroes it when enabled
    bias_in = {LANES{8'h02}}; bias_load = 1'b1;
    step();
    bias_load = 1'b0; in_data = {LANES{8'hF0}}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
`ifdef BIAS_ADD_RELU_EN
    exp_v = '0;
`else
    exp_v = {LANES{8'hF2}};
`endif
    chk("relu_data", out_data, exp_v);
    chk("relu_sat", out_sat, '0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
